// File: rtl/vec_pkg.sv
// Shared vector-unit definitions: register geometry, the register type and the
// tail-undisturbed merge used by writeback.
package vec_pkg;

    localparam int VLEN        = 256;
    localparam int ELEM_SIZE   = 32;
    localparam int NUMELEMS    = VLEN / ELEM_SIZE;
    localparam int VREG_ADDR_W = 5;
    localparam int VL_W        = $clog2(NUMELEMS) + 1;

    typedef logic [VLEN-1:0]        vreg_t;
    typedef logic [VREG_ADDR_W-1:0] vaddr_t;

    // Elements below vl take the new value; the tail keeps the old register contents.
    function automatic vreg_t tail_merge(input vreg_t new_v, input vreg_t old_v,
                                         input logic [VL_W-1:0] vl);
        vreg_t r;
        r = old_v;
        for (int i = 0; i < NUMELEMS; i++) begin
            if (int'(vl) > i) begin
                r[i*ELEM_SIZE +: ELEM_SIZE] = new_v[i*ELEM_SIZE +: ELEM_SIZE];
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/vrf_array.sv
// Architectural vector register storage: one write port, three combinational
// read ports, everything cleared by synchronous reset.
module vrf_array
    import vec_pkg::*;
#(
    parameter int NUM_REGS = 32
) (
    input  logic   clk,
    input  logic   rst,
    input  logic   we,
    input  vaddr_t waddr,
    input  vreg_t  wdata,
    input  vaddr_t raddr1,
    output vreg_t  rdata1,
    input  vaddr_t raddr2,
    output vreg_t  rdata2,
    input  vaddr_t raddr3,
    output vreg_t  rdata3
);

    vreg_t mem [NUM_REGS];

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                mem[i] <= '0;
            end
        end else if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata1 = mem[raddr1];
    assign rdata2 = mem[raddr2];
    assign rdata3 = mem[raddr3];

endmodule

// File: rtl/vrf_wb.sv
// Vector register file with ALU writeback (tail-undisturbed merge), result
// forwarding to the issue slot, and a lower-priority vector-load write port.
module vrf_wb #(
    parameter int VLEN      = 256,
    parameter int ELEM_SIZE = 32,
    parameter int NUM_VREGS = 32,
    parameter int VL_W      = $clog2(VLEN/ELEM_SIZE) + 1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            iss_valid,
    output logic            iss_ready,
    input  logic [4:0]      iss_vs1,
    input  logic [4:0]      iss_vs2,
    input  logic [4:0]      iss_vd,
    input  logic            iss_we,
    input  logic [VL_W-1:0] iss_vl,
    output logic [VLEN-1:0] op1,
    output logic [VLEN-1:0] op2,
    input  logic [VLEN-1:0] alu_result,
    input  logic            ld_valid,
    output logic            ld_ready,
    input  logic [4:0]      ld_vd,
    input  logic [VLEN-1:0] ld_data,
    output logic            wb_valid,
    output logic [4:0]      wb_vd,
    input  logic [4:0]      dbg_raddr,
    output logic [VLEN-1:0] dbg_rdata
);

    localparam int NEL = VLEN / ELEM_SIZE;

    // Handshakes: a transfer happens in exactly the cycle where valid && ready are
    // both high. The issue slot is ready whenever out of reset; the load port is
    // ready only when no ALU writeback owns the write port, and a refused load
    // must simply be held until it is accepted.
    logic            fire;
    logic            wb_act;
    logic            ld_fire;
    logic [VL_W-1:0] vl_clamped;

    logic            wb_pend;
    logic [4:0]      wb_vd_q;
    logic [VL_W-1:0] wb_vl_q;
    logic [VLEN-1:0] old_q;
    logic [VLEN-1:0] wb_data;
    logic [VLEN-1:0] old_fwd;

    logic            arr_we;
    logic [4:0]      arr_waddr;
    logic [VLEN-1:0] arr_wdata;
    logic [VLEN-1:0] rd_vs1;
    logic [VLEN-1:0] rd_vs2;
    logic [VLEN-1:0] rd_p3;
    logic [4:0]      p3_addr;
    logic            p3_old;

    assign iss_ready  = !rst;
    assign fire       = iss_valid && !rst;
    assign wb_act     = wb_pend && !rst;
    assign ld_ready   = !rst && !wb_pend;
    assign ld_fire    = ld_valid && ld_ready;
    assign vl_clamped = (iss_vl > VL_W'(NEL)) ? VL_W'(NEL) : iss_vl;
    assign wb_data    = vec_pkg::tail_merge(alu_result, old_q, wb_vl_q);

    assign arr_we    = wb_act || ld_fire;
    assign arr_waddr = wb_act ? wb_vd_q : ld_vd;
    assign arr_wdata = wb_act ? wb_data : ld_data;

    // The third read port serves the old-vd capture while a writing issue is
    // presented and the debug address otherwise.
    assign p3_old  = iss_valid && iss_we;
    assign p3_addr = p3_old ? iss_vd : dbg_raddr;

    vrf_array #(
        .NUM_REGS(NUM_VREGS)
    ) u_array (
        .clk    (clk),
        .rst    (rst),
        .we     (arr_we),
        .waddr  (arr_waddr),
        .wdata  (arr_wdata),
        .raddr1 (iss_vs1),
        .rdata1 (rd_vs1),
        .raddr2 (iss_vs2),
        .rdata2 (rd_vs2),
        .raddr3 (p3_addr),
        .rdata3 (rd_p3)
    );

    // In-flight ALU result beats an accepted load, which beats the register contents.
    always_comb begin
        op1 = rd_vs2;
        if (wb_act && wb_vd_q == iss_vs2) begin
            op1 = wb_data;
        end else if (ld_fire && ld_vd == iss_vs2) begin
            op1 = ld_data;
        end
        if (rst) begin
            op1 = '0;
        end
    end

    always_comb begin
        op2 = rd_vs1;
        if (wb_act && wb_vd_q == iss_vs1) begin
            op2 = wb_data;
        end else if (ld_fire && ld_vd == iss_vs1) begin
            op2 = ld_data;
        end
        if (rst) begin
            op2 = '0;
        end
    end

    always_comb begin
        old_fwd = rd_p3;
        if (wb_act && wb_vd_q == iss_vd) begin
            old_fwd = wb_data;
        end else if (ld_fire && ld_vd == iss_vd) begin
            old_fwd = ld_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wb_pend <= 1'b0;
            wb_vd_q <= '0;
            wb_vl_q <= '0;
            old_q   <= '0;
        end else begin
            wb_pend <= fire && iss_we;
            if (fire) begin
                wb_vd_q <= iss_vd;
                wb_vl_q <= vl_clamped;
                old_q   <= old_fwd;
            end
        end
    end

    assign wb_valid  = wb_act;
    assign wb_vd     = wb_act ? wb_vd_q : '0;
    assign dbg_rdata = rst ? '0 : rd_p3;

endmodule

// File: doc/vrf_wb.md
# vrf_wb

Vector register file and writeback stage around the vector ALU. Holds the architectural vector registers and drives the ALU operand buses combinationally from the accepted issue slot. It captures the ALU result one cycle later and writes it back to the destination register, leaving tail elements undisturbed, and forwards the in-flight result to dependent instructions. A second write port accepts vector-load data from the memory unit under a valid/ready handshake; ALU writeback takes priority.

## Interface
Parameters:
- `VLEN`, 256, vector register width in bits
- `ELEM_SIZE`, 32, element width in bits
- `NUM_VREGS`, 32, number of vector registers
- `VL_W`, `$clog2(VLEN/ELEM_SIZE)+1`, width of vl fields

Ports:
- `clk` in 1: the block's single clock
- `rst` in 1: synchronous, active-high reset
- `iss_valid` in 1: issue slot holds an instruction
- `iss_ready` out 1: block accepts the issue; equals `!rst`
- `iss_vs1` in 5: source register routed to `op2`
- `iss_vs2` in 5: source register routed to `op1`
- `iss_vd` in 5: destination register
- `iss_we` in 1: the instruction writes `vd`
- `iss_vl` in VL_W: active element count
- `op1` out VLEN: ALU operand, from vs2
- `op2` out VLEN: ALU operand, from vs1
- `alu_result` in VLEN: ALU registered result, valid the cycle after issue
- `ld_valid` in 1: load write request
- `ld_ready` out 1: load write accepted this cycle
- `ld_vd` in 5: load destination register
- `ld_data` in VLEN: load data (full register)
- `wb_valid` out 1: ALU writeback commits this cycle
- `wb_vd` out 5: register being written by the ALU
- `dbg_raddr` in 5: debug read address
- `dbg_rdata` out VLEN: debug read data; bypass-free, architectural state only

## Operation
- Issue fires when `iss_valid && iss_ready`. On fire, capture `iss_vd`, `iss_we` and the clamped vl into the writeback register, and capture the old `vd` contents for the tail merge. The clamped vl is `min(iss_vl, VLEN/ELEM_SIZE)`.
- Pending writeback state: `wb_pend <= fire && iss_we`. `wb_valid = wb_pend`.
- Merge value `wb_data`: element i is `alu_result` element i when `i < wb_vl`, otherwise the captured old `vd` element i.
  - vl = 0 writes the old value back unchanged, and `wb_valid` still pulses.
- Register write priority in a cycle:
  - ALU writeback writes `wb_data` to `wb_vd` when `wb_pend`.
  - Otherwise, if `ld_valid`, write `ld_data` to `ld_vd`.
  - `ld_ready = !rst && !wb_pend`.
- Operand read for vs1 and vs2 independently, with forwarding. The first matching source wins:
  1. `wb_pend && wb_vd == vs`: use `wb_data`.
  2. `ld_valid && ld_ready && ld_vd == vs`: use `ld_data`.
  3. Otherwise use the register contents.
- The same forwarding applies to the old-`vd` capture at issue.
- `op1` and `op2` are driven regardless of `iss_valid`; the ALU ignores them unless the instruction issued.
- v0 is an ordinary register; there is no hardwired zero.
- Reset clears all registers to 0 and clears `wb_pend`.
  - An issue or load presented during reset is dropped.
  - A writeback pending at reset assertion is discarded, and its register keeps its pre-reset-cycle value.

## Timing
- Cycle T: issue fires, and `op1`/`op2` are valid combinationally.
- The ALU registers the result at the end of T.
- Cycle T+1: `wb_valid`=1 and `alu_result` is valid. The VRF is updated at the end of T+1.
- Architectural read latency of the result is 2 cycles. A dependent instruction issued at T+1 gets the value through forwarding, with zero stall.
- Back-to-back issue every cycle is sustained. In that case `ld_ready` stays low for as long as writebacks occur.
- Load write: accepted in the cycle `ld_valid && ld_ready`; visible in the register contents from the next cycle, and forwarded in the same cycle.
- All outputs are 0 during reset and in the first cycle after it, except `iss_ready` and `ld_ready`, which go to 1 after reset.

## Structure
- Shared package `vec_pkg`:
  - `VLEN`, `ELEM_SIZE`, `NUMELEMS`, `VREG_ADDR_W`=5
  - the `vreg_t` typedef (`logic [VLEN-1:0]`)
  - the tail-merge function
- Sub-module `vrf_array`:
  - storage with synchronous reset
  - one write port and three combinational read ports: vs1, vs2, debug/old-vd mux
  - writeback, forwarding and the load handshake stay in `vrf_wb`
- The ALU is instantiated by the parent; `vrf_wb` does not contain it.

## Test plan
- Reset, then read all 32 registers via `dbg_raddr` -> all 0; `wb_valid`=0, `ld_ready`=1.
- Load v1 with all elements 5 and v2 with all elements 3. Issue vadd vd=v3, vs2=v1, vs1=v2, vl=8 -> `wb_valid` at T+1, v3 has all elements 8 at T+2.
- Preload v4 with all elements 0xAA. Issue a write to v4 with vl=3 and `alu_result` elements all 1 -> v4 = {1,1,1,0xAA×5}. With vl=0, v4 is unchanged but `wb_valid` still pulses. With vl=15, the value clamps to 8.
- Issue v5 = v1 + v2, then the next cycle issue vs2=v5 -> `op1` equals the forwarded value 8 per element with no stall.
- Hold `ld_valid` to v6 during two back-to-back ALU writebacks -> `ld_ready`=0 for those 2 cycles, the load is accepted on the 3rd cycle, and v6 is correct. Simultaneous ALU writeback and load to the same vd -> the ALU value is written and the load is retried.
- Assert `rst` in the cycle after an issue that writes v7=9s -> v7 reads 0 after reset and `wb_valid` never pulses.
